bumpy_motion_ctrl: RTL and testbench
====================================

# bumpy_motion_ctrl

Parametrised successor to the Bumpy movement FSM, adding lives, respawn, post-respawn invulnerability and a bounded jump. It sits between the keypad/collision logic and the Bumpy motion/draw object. It decodes active-low keys plus collision flags into a registered movement state. It also drives the die, respawn and game-over pulses and flags consumed by the game controller and score/lives display.

## Interface
- LIVES, 3: lives loaded at reset; 1..15.
- JUMP_FRAMES, 16: max frames in UP before a forced fall; 1..2^CNT_W-1.
- RESPAWN_FRAMES, 60: frames spent in DYING; 1..2^CNT_W-1.
- INVULN_FRAMES, 90: frames of invulnerability after respawn; 0..2^CNT_W-1.
- CNT_W, 8: width of each frame counter.
- clk  in  1  system clock; the one clock.
- reset  in  1  asynchronous, active-high reset.
- start_of_frame  in  1  one-cycle pulse per video frame; all frame counters advance only on it.
- up_direction, left_direction, right_direction, down_direction  in  1 each  keys, active-low.
- step_collision, free_collision, border_collision, spike_collision  in  1 each  collision flags, same cycle as HitEdgeCode.
- HitEdgeCode  in  4  {Left,Top,Right,Bottom}, one-hot.
- state  out  4  current state code.
- die  out  1  one-cycle pulse on entry to DYING.
- respawn  out  1  one-cycle pulse on DYING→DOWN; motion object reloads its start position.
- lives  out  4  remaining lives.
- game_over  out  1  high while in GAMEOVER.
- invuln  out  1  high while the invulnerability counter is nonzero.

## Operation
- State codes are fixed: RESET=0, IDLE=1, LEFT=2, RIGHT=3, DOWN=4, UP=5, DYING=6, GAMEOVER=7. Codes 8..15 are unused and recover to RESET.
- Keys are used inverted: key = !direction.
- bottom_hit = HitEdgeCode==4'b0001. Other edge tests also use equality against a one-hot value.
- fatal = !invuln && (spike_collision || (border_collision && bottom_hit)). It has highest priority in IDLE, LEFT, RIGHT, DOWN and UP.
- RESET: any key → DOWN.
- IDLE:
  - step_collision && bottom_hit: up→UP, else left→LEFT, else right→RIGHT, else stay.
  - free_collision && bottom_hit (walked off an edge) → DOWN.
- LEFT, RIGHT, DOWN (priority order after fatal):
  - RIGHT with border_collision && Right edge → LEFT.
  - LEFT with border_collision && Left edge → RIGHT.
  - step_collision && bottom_hit: up→UP, left→LEFT, right→RIGHT, else IDLE.
  - Otherwise hold.
- UP (priority order after fatal):
  - down key → DOWN.
  - free_collision && bottom_hit && left → LEFT; same with right → RIGHT.
  - border_collision, or step_collision with Top edge → DOWN.
  - Jump expiry → DOWN.
  - Otherwise hold.
- Jump counter: loaded with JUMP_FRAMES on every entry to UP. It decrements on start_of_frame while in UP. Expiry is start_of_frame while the counter is 1.
- DYING:
  - On entry: lives decrements, saturating at 0, and the respawn counter loads RESPAWN_FRAMES.
  - The counter decrements on start_of_frame.
  - When the counter is 1 and start_of_frame occurs: lives==0 → GAMEOVER, else → DOWN with respawn and invuln counter = INVULN_FRAMES.
- GAMEOVER: absorbing until reset.
- Invuln counter: decrements on start_of_frame in any state until 0. Non-fatal transitions proceed normally while invuln.

## Timing
- All outputs registered. Reset values: state=0, die=0, respawn=0, lives=LIVES, game_over=0, invuln=0, all counters=0.
- Inputs sampled at clk edge N; the new state is visible after edge N (1-cycle latency).
- die and respawn are each high exactly one cycle, the first cycle of the new state.
- A counter load on state entry overrides a start_of_frame in the same cycle; that pulse is not counted.
- UP lasts exactly JUMP_FRAMES start_of_frame pulses absent other events.
- DYING lasts exactly RESPAWN_FRAMES pulses.
- Invulnerability covers INVULN_FRAMES pulses counted after respawn.
- fatal in the same cycle as the invuln counter reaching 0: the registered invuln still reads 1, so it is ignored.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronous). Release is effective from the next clk edge.

## Test plan
- Reset, right_direction=0 → DOWN next cycle. Then step_collision + HitEdgeCode=0001, no keys → IDLE; lives=3.
- In RIGHT, border_collision + HitEdgeCode=0010 → LEFT. Then border_collision + 1000 → RIGHT. die stays 0.
- In UP with JUMP_FRAMES=4, no collisions, 4 start_of_frame pulses → DOWN on the cycle after the 4th. down_direction=0 earlier → immediate DOWN.
- spike_collision in LEFT → die pulse of 1 cycle, lives 3→2. After 60 frames → DOWN with respawn pulse and invuln=1. spike_collision within the next 90 frames → no transition.
- Three deaths with LIVES=3 → lives=0. After the respawn delay → GAMEOVER, game_over=1, keys ignored. reset → state 0, lives=3.
- Simultaneous step_collision bottom with up and left keys in DOWN → UP (up wins). Reset pulsed while in DYING → state 0 at once, die=0.

Source files
------------

// File: rtl/bumpy_motion_ctrl.sv
// rtl/bumpy_motion_ctrl.sv - Bumpy movement FSM with lives, respawn, invulnerability and bounded jump
module bumpy_motion_ctrl #(
    parameter int LIVES          = 3,
    parameter int JUMP_FRAMES    = 16,
    parameter int RESPAWN_FRAMES = 60,
    parameter int INVULN_FRAMES  = 90,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_of_frame,
    input  logic       up_direction,
    input  logic       left_direction,
    input  logic       right_direction,
    input  logic       down_direction,
    input  logic       step_collision,
    input  logic       free_collision,
    input  logic       border_collision,
    input  logic       spike_collision,
    input  logic [3:0] HitEdgeCode,
    output logic [3:0] state,
    output logic       die,
    output logic       respawn,
    output logic [3:0] lives,
    output logic       game_over,
    output logic       invuln
);

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_IDLE     = 4'd1,
        ST_LEFT     = 4'd2,
        ST_RIGHT    = 4'd3,
        ST_DOWN     = 4'd4,
        ST_UP       = 4'd5,
        ST_DYING    = 4'd6,
        ST_GAMEOVER = 4'd7
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_JUMP   = CNT_W'(JUMP_FRAMES);
    localparam logic [CNT_W-1:0] CNT_RESP   = CNT_W'(RESPAWN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_INVULN = CNT_W'(INVULN_FRAMES);
    localparam logic [3:0]       LIVES_INIT = 4'(LIVES);

    // HitEdgeCode bit order is {Left, Top, Right, Bottom}
    localparam logic [3:0] EDGE_LEFT   = 4'b1000;
    localparam logic [3:0] EDGE_TOP    = 4'b0100;
    localparam logic [3:0] EDGE_RIGHT  = 4'b0010;
    localparam logic [3:0] EDGE_BOTTOM = 4'b0001;

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] jump_cnt;
    logic [CNT_W-1:0] resp_cnt;
    logic [CNT_W-1:0] inv_cnt;

    logic key_up;
    logic key_left;
    logic key_right;
    logic key_down;
    logic any_key;
    logic bottom_hit;
    logic top_hit;
    logic left_hit;
    logic right_hit;
    logic fatal;
    logic jump_expire;
    logic resp_done;
    logic enter_dying;
    logic enter_up;
    logic do_respawn;

    assign key_up    = !up_direction;
    assign key_left  = !left_direction;
    assign key_right = !right_direction;
    assign key_down  = !down_direction;
    assign any_key   = key_up || key_left || key_right || key_down;

    assign bottom_hit = (HitEdgeCode == EDGE_BOTTOM);
    assign top_hit    = (HitEdgeCode == EDGE_TOP);
    assign left_hit   = (HitEdgeCode == EDGE_LEFT);
    assign right_hit  = (HitEdgeCode == EDGE_RIGHT);

    // The registered invuln flag gates death, so a hit on the frame the counter drains is still forgiven
    assign fatal = !invuln && (spike_collision || (border_collision && bottom_hit));

    assign jump_expire = start_of_frame && (jump_cnt == CNT_ONE);
    assign resp_done   = start_of_frame && (resp_cnt == CNT_ONE);

    assign enter_dying = (nxt_state == ST_DYING) && (cur_state != ST_DYING);
    assign enter_up    = (nxt_state == ST_UP) && (cur_state != ST_UP);
    assign do_respawn  = (cur_state == ST_DYING) && (nxt_state == ST_DOWN);

    assign state = cur_state;

    // Next-state decode from keys, collisions and frame counters
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_RESET: begin
                if (any_key) nxt_state = ST_DOWN;
            end
            ST_IDLE: begin
                if (fatal) begin
                    nxt_state = ST_DYING;
                end else if (step_collision && bottom_hit) begin
                    if (key_up)         nxt_state = ST_UP;
                    else if (key_left)  nxt_state = ST_LEFT;
                    else if (key_right) nxt_state = ST_RIGHT;
                end else if (free_collision && bottom_hit) begin
                    nxt_state = ST_DOWN;
                end
            end
            ST_LEFT, ST_RIGHT, ST_DOWN: begin
                if (fatal) begin
                    nxt_state = ST_DYING;
                end else if ((cur_state == ST_RIGHT) && border_collision && right_hit) begin
                    nxt_state = ST_LEFT;
                end else if ((cur_state == ST_LEFT) && border_collision && left_hit) begin
                    nxt_state = ST_RIGHT;
                end else if (step_collision && bottom_hit) begin
                    if (key_up)         nxt_state = ST_UP;
                    else if (key_left)  nxt_state = ST_LEFT;
                    else if (key_right) nxt_state = ST_RIGHT;
                    else                nxt_state = ST_IDLE;
                end
            end
            ST_UP: begin
                if (fatal) begin
                    nxt_state = ST_DYING;
                end else if (key_down) begin
                    nxt_state = ST_DOWN;
                end else if (free_collision && bottom_hit && key_left) begin
                    nxt_state = ST_LEFT;
                end else if (free_collision && bottom_hit && key_right) begin
                    nxt_state = ST_RIGHT;
                end else if (border_collision || (step_collision && top_hit)) begin
                    nxt_state = ST_DOWN;
                end else if (jump_expire) begin
                    nxt_state = ST_DOWN;
                end
            end
            ST_DYING: begin
                if (resp_done) begin
                    if (lives == 4'd0) nxt_state = ST_GAMEOVER;
                    else               nxt_state = ST_DOWN;
                end
            end
            ST_GAMEOVER: begin
                nxt_state = ST_GAMEOVER;
            end
            default: begin
                nxt_state = ST_RESET;
            end
        endcase
    end

    // State, frame counters and all registered outputs; counter loads on entry win over a same-cycle frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_RESET;
            die       <= 1'b0;
            respawn   <= 1'b0;
            lives     <= LIVES_INIT;
            game_over <= 1'b0;
            invuln    <= 1'b0;
            jump_cnt  <= '0;
            resp_cnt  <= '0;
            inv_cnt   <= '0;
        end else begin
            cur_state <= nxt_state;
            die       <= enter_dying;
            respawn   <= do_respawn;
            game_over <= (nxt_state == ST_GAMEOVER);

            if (enter_dying) begin
                lives    <= (lives == 4'd0) ? 4'd0 : lives - 4'd1;
                resp_cnt <= CNT_RESP;
            end else if ((cur_state == ST_DYING) && start_of_frame && (resp_cnt != '0)) begin
                resp_cnt <= resp_cnt - CNT_ONE;
            end

            if (enter_up) begin
                jump_cnt <= CNT_JUMP;
            end else if ((cur_state == ST_UP) && start_of_frame && (jump_cnt != '0)) begin
                jump_cnt <= jump_cnt - CNT_ONE;
            end

            if (do_respawn) begin
                inv_cnt <= CNT_INVULN;
                invuln  <= (CNT_INVULN != '0);
            end else if (start_of_frame && (inv_cnt != '0)) begin
                inv_cnt <= inv_cnt - CNT_ONE;
                invuln  <= (inv_cnt != CNT_ONE);
            end
        end
    end

endmodule

// File: tb/tb_bumpy_motion_ctrl.sv
// tb/tb_bumpy_motion_ctrl.sv - Self-checking scoreboard bench for bumpy_motion_ctrl
module tb_bumpy_motion_ctrl;

    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_IDLE     = 4'd1;
    localparam logic [3:0] S_LEFT     = 4'd2;
    localparam logic [3:0] S_RIGHT    = 4'd3;
    localparam logic [3:0] S_DOWN     = 4'd4;
    localparam logic [3:0] S_UP       = 4'd5;
    localparam logic [3:0] S_DYING    = 4'd6;
    localparam logic [3:0] S_GAMEOVER = 4'd7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_of_frame;
    logic       up_direction, left_direction, right_direction, down_direction;
    logic       step_collision, free_collision, border_collision, spike_collision;
    logic [3:0] HitEdgeCode;
    logic [3:0] state;
    logic       die, respawn, game_over, invuln;
    logic [3:0] lives;

    logic [11:0] exp_q[$];
    logic [11:0] exp_v;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bumpy_motion_ctrl #(
        .LIVES(3), .JUMP_FRAMES(4), .RESPAWN_FRAMES(60), .INVULN_FRAMES(90), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .start_of_frame(start_of_frame),
        .up_direction(up_direction), .left_direction(left_direction),
        .right_direction(right_direction), .down_direction(down_direction),
        .step_collision(step_collision), .free_collision(free_collision),
        .border_collision(border_collision), .spike_collision(spike_collision),
        .HitEdgeCode(HitEdgeCode), .state(state), .die(die), .respawn(respawn),
        .lives(lives), .game_over(game_over), .invuln(invuln)
    );

    function automatic logic [11:0] pk(input logic [3:0] st, input logic d, input logic r,
                                       input logic [3:0] l, input logic g, input logic i);
        return {st, d, r, l, g, i};
    endfunction

    function automatic logic [11:0] obs();
        return {state, die, respawn, lives, game_over, invuln};
    endfunction

    task automatic idle_inputs();
        start_of_frame = 0;
        up_direction = 1; left_direction = 1; right_direction = 1; down_direction = 1;
        step_collision = 0; free_collision = 0; border_collision = 0; spike_collision = 0;
        HitEdgeCode = 4'b0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        exp_q.push_back(pk(S_RESET, 0, 0, 4'd3, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL reset_state: got %h expected %h", obs(), exp_v); end
        reset = 0;
        exp_q.push_back(pk(S_RESET, 0, 0, 4'd3, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL reset_no_key_hold: got %h expected %h", obs(), exp_v); end
    endtask

    task automatic test_start_idle();
        right_direction = 0;
        exp_q.push_back(pk(S_DOWN, 0, 0, 4'd3, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL start_down: got %h expected %h", obs(), exp_v); end
        idle_inputs();
        step_collision = 1; HitEdgeCode = 4'b0001;
        exp_q.push_back(pk(S_IDLE, 0, 0, 4'd3, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL land_idle: got %h expected %h", obs(), exp_v); end
        idle_inputs();
        free_collision = 1; HitEdgeCode = 4'b0010;
        exp_q.push_back(pk(S_IDLE, 0, 0, 4'd3, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL idle_free_not_bottom: got %h expected %h", obs(), exp_v); end
        idle_inputs();
    endtask

    task automatic test_border();
        logic [3:0] edges [3];
        logic [3:0] want  [3];
        edges[0] = 4'b0001; edges[1] = 4'b0010; edges[2] = 4'b1000;
        want[0]  = S_RIGHT; want[1]  = S_LEFT;  want[2]  = S_RIGHT;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            if (i == 0) begin step_collision = 1; right_direction = 0; end
            else border_collision = 1;
            HitEdgeCode = edges[i];
            exp_q.push_back(pk(want[i], 0, 0, 4'd3, 0, 0));
            tick();
            exp_v = exp_q.pop_front(); checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL border_step%0d: got %h expected %h", i, obs(), exp_v); end
        end
        idle_inputs();
    endtask

    task automatic test_jump();
        step_collision = 1; HitEdgeCode = 4'b0001; up_direction = 0;
        exp_q.push_back(pk(S_UP, 0, 0, 4'd3, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL jump_enter: got %h expected %h", obs(), exp_v); end
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            start_of_frame = 1;
            exp_q.push_back(pk((i == 4) ? S_DOWN : S_UP, 0, 0, 4'd3, 0, 0));
            tick();
            exp_v = exp_q.pop_front(); checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL jump_frame%0d: got %h expected %h", i, obs(), exp_v); end
            start_of_frame = 0;
            if (i < 4) begin
                exp_q.push_back(pk(S_UP, 0, 0, 4'd3, 0, 0));
                tick();
                exp_v = exp_q.pop_front(); checks++;
                if (obs() !== exp_v) begin errors++; $display("FAIL jump_gap%0d: got %h expected %h", i, obs(), exp_v); end
            end
        end
        step_collision = 1; HitEdgeCode = 4'b0001; up_direction = 0;
        exp_q.push_back(pk(S_UP, 0, 0, 4'd3, 0, 0));
        tick();
        idle_inputs();
        down_direction = 0;
        exp_q.push_back(pk(S_DOWN, 0, 0, 4'd3, 0, 0));
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL jump_reenter: got %h expected %h", obs(), exp_v); end
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL jump_down_key: got %h expected %h", obs(), exp_v); end
        idle_inputs();
    endtask

    task automatic test_simultaneous_keys();
        step_collision = 1; HitEdgeCode = 4'b0001; up_direction = 0; left_direction = 0;
        exp_q.push_back(pk(S_UP, 0, 0, 4'd3, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL up_beats_left: got %h expected %h", obs(), exp_v); end
        idle_inputs();
        down_direction = 0;
        exp_q.push_back(pk(S_DOWN, 0, 0, 4'd3, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL simul_exit_down: got %h expected %h", obs(), exp_v); end
        idle_inputs();
    endtask

    task automatic test_death_respawn();
        step_collision = 1; HitEdgeCode = 4'b0001; left_direction = 0;
        exp_q.push_back(pk(S_LEFT, 0, 0, 4'd3, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL death_to_left: got %h expected %h", obs(), exp_v); end
        idle_inputs();
        spike_collision = 1;
        exp_q.push_back(pk(S_DYING, 1, 0, 4'd2, 0, 0));
        tick();
        idle_inputs();
        exp_q.push_back(pk(S_DYING, 0, 0, 4'd2, 0, 0));
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL spike_die: got %h expected %h", obs(), exp_v); end
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL die_one_cycle: got %h expected %h", obs(), exp_v); end
        for (int i = 1; i <= 60; i++) begin
            start_of_frame = 1;
            if (i < 60) exp_q.push_back(pk(S_DYING, 0, 0, 4'd2, 0, 0));
            else        exp_q.push_back(pk(S_DOWN, 0, 1, 4'd2, 0, 1));
            tick();
            exp_v = exp_q.pop_front(); checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL respawn_frame%0d: got %h expected %h", i, obs(), exp_v); end
        end
        idle_inputs();
        exp_q.push_back(pk(S_DOWN, 0, 0, 4'd2, 0, 1));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL respawn_one_cycle: got %h expected %h", obs(), exp_v); end
        for (int i = 1; i <= 90; i++) begin
            spike_collision = 1; start_of_frame = 1;
            exp_q.push_back(pk(S_DOWN, 0, 0, 4'd2, 0, (i < 90) ? 1'b1 : 1'b0));
            tick();
            exp_v = exp_q.pop_front(); checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL invuln_frame%0d: got %h expected %h", i, obs(), exp_v); end
        end
        idle_inputs();
        spike_collision = 1;
        exp_q.push_back(pk(S_DYING, 1, 0, 4'd1, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL second_death: got %h expected %h", obs(), exp_v); end
        idle_inputs();
    endtask

    task automatic test_gameover();
        for (int i = 1; i <= 60; i++) begin
            start_of_frame = 1;
            if (i < 60) exp_q.push_back(pk(S_DYING, 0, 0, 4'd1, 0, 0));
            else        exp_q.push_back(pk(S_DOWN, 0, 1, 4'd1, 0, 1));
            tick();
            exp_v = exp_q.pop_front(); checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL respawn2_frame%0d: got %h expected %h", i, obs(), exp_v); end
        end
        for (int i = 1; i <= 90; i++) begin
            exp_q.push_back(pk(S_DOWN, 0, 0, 4'd1, 0, (i < 90) ? 1'b1 : 1'b0));
            tick();
            exp_v = exp_q.pop_front(); checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL invuln2_frame%0d: got %h expected %h", i, obs(), exp_v); end
        end
        idle_inputs();
        border_collision = 1; HitEdgeCode = 4'b0001;
        exp_q.push_back(pk(S_DYING, 1, 0, 4'd0, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL third_death: got %h expected %h", obs(), exp_v); end
        idle_inputs();
        for (int i = 1; i <= 60; i++) begin
            start_of_frame = 1;
            if (i < 60) exp_q.push_back(pk(S_DYING, 0, 0, 4'd0, 0, 0));
            else        exp_q.push_back(pk(S_GAMEOVER, 0, 0, 4'd0, 1, 0));
            tick();
            exp_v = exp_q.pop_front(); checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL gameover_frame%0d: got %h expected %h", i, obs(), exp_v); end
        end
        up_direction = 0; left_direction = 0; right_direction = 0; down_direction = 0;
        step_collision = 1; HitEdgeCode = 4'b0001; start_of_frame = 0;
        exp_q.push_back(pk(S_GAMEOVER, 0, 0, 4'd0, 1, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL gameover_absorb: got %h expected %h", obs(), exp_v); end
        idle_inputs();
        reset = 1;
        #2;
        exp_q.push_back(pk(S_RESET, 0, 0, 4'd3, 0, 0));
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL gameover_reset: got %h expected %h", obs(), exp_v); end
        reset = 0;
        tick();
    endtask

    task automatic test_reset_in_dying();
        right_direction = 0;
        exp_q.push_back(pk(S_DOWN, 0, 0, 4'd3, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL rd_down: got %h expected %h", obs(), exp_v); end
        idle_inputs();
        spike_collision = 1;
        exp_q.push_back(pk(S_DYING, 1, 0, 4'd2, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL rd_dying: got %h expected %h", obs(), exp_v); end
        idle_inputs();
        #1;
        reset = 1;
        #1;
        exp_q.push_back(pk(S_RESET, 0, 0, 4'd3, 0, 0));
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL rd_async_reset: got %h expected %h", obs(), exp_v); end
        tick();
        reset = 0;
        exp_q.push_back(pk(S_RESET, 0, 0, 4'd3, 0, 0));
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL rd_after_release: got %h expected %h", obs(), exp_v); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_start_idle();
        test_border();
        test_jump();
        test_simultaneous_keys();
        test_death_respawn();
        test_gameover();
        test_reset_in_dying();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
